// File: rtl/mmio_fifo_pkg.sv
// Shared constants and types for the MMIO FIFO register block.
// Register word offsets, STATUS/CTRL bit positions and the STATUS layout.
package mmio_fifo_pkg;

   localparam logic [2:0] OFS_DATA   = 3'd0;
   localparam logic [2:0] OFS_STATUS = 3'd2;
   localparam logic [2:0] OFS_PEEK   = 3'd4;
   localparam logic [2:0] OFS_CTRL   = 3'd6;

   localparam int ST_EMPTY = 32;
   localparam int ST_FULL  = 33;
   localparam int ST_OVF   = 34;
   localparam int ST_UDF   = 35;

   localparam int CTRL_FLUSH = 0;
   localparam int CTRL_CLR   = 1;

   typedef struct packed {
      logic [27:0] rsvd_hi;
      logic        udf;
      logic        ovf;
      logic        full;
      logic        empty;
      logic [23:0] rsvd_lo;
      logic [7:0]  count;
   } status_t;

   // The block owns an 8-word aligned window starting at base.
   function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base);
      return addr[15:3] == base[15:3];
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Synchronous FIFO storage with gated push/pop and a flush.
// A push into a full FIFO is accepted when a pop frees a slot in the same cycle.
module sync_fifo_ram #(
   parameter  int DATA_W = 64,
   parameter  int DEPTH  = 8,
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic              flush,
   output logic [DATA_W-1:0] head,
   output logic [CW-1:0]     count,
   output logic              empty,
   output logic              full
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr, wr_ptr;
   logic              do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mmio_fifo_regs.sv
// MMIO-mapped FIFO register block: DATA push/pop, STATUS, PEEK and CTRL.
// Read responses are registered one cycle after the request from pre-write state.
module mmio_fifo_regs
   import mmio_fifo_pkg::*;
#(
   parameter int          DATA_W    = 64,
   parameter int          DEPTH     = 8,
   parameter logic [15:0] BASE_ADDR = 16'h0020,
   parameter int          AF_THRESH = DEPTH - 2,
   parameter int          TID_W     = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   input  logic [15:0]      wr_addr,
   input  logic [63:0]      wr_data,
   input  logic             rd_valid,
   input  logic [15:0]      rd_addr,
   input  logic [TID_W-1:0] rd_tid,
   output logic             rsp_valid,
   output logic [TID_W-1:0] rsp_tid,
   output logic [63:0]      rsp_data,
   output logic             rsp_hit,
   output logic             almost_full,
   output logic             empty,
   output logic             full
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);

   logic              wr_in, rd_in;
   logic              push, pop, flush, clr;
   logic              ovf, udf, ovf_set, udf_set;
   logic [DATA_W-1:0] head;
   logic [CW-1:0]     count;
   logic [63:0]       head_ext, rd_word;
   status_t           st;

   assign wr_in = in_window(wr_addr, BASE_ADDR);
   assign rd_in = in_window(rd_addr, BASE_ADDR);
   assign push  = wr_valid && wr_in && (wr_addr[2:0] == OFS_DATA);
   assign pop   = rd_valid && rd_in && (rd_addr[2:0] == OFS_DATA);
   assign flush = wr_valid && wr_in && (wr_addr[2:0] == OFS_CTRL) && wr_data[CTRL_FLUSH];
   assign clr   = wr_valid && wr_in && (wr_addr[2:0] == OFS_CTRL) && wr_data[CTRL_CLR];

   // A push at full is not an overflow when a same-cycle pop frees the slot.
   assign ovf_set = push && full && !pop;
   assign udf_set = pop && empty;

   sync_fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (wr_data[DATA_W-1:0]),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .count     (count),
      .empty     (empty),
      .full      (full)
   );

   assign almost_full = (count >= AF_C);

   always_comb begin
      head_ext = '0;
      head_ext[DATA_W-1:0] = head;
      st       = '0;
      st.count = 8'(count);
      st.empty = empty;
      st.full  = full;
      st.ovf   = ovf;
      st.udf   = udf;
   end

   always_comb begin
      rd_word = '0;
      if (rd_in) begin
         case (rd_addr[2:0])
            OFS_DATA, OFS_PEEK: if (!empty) rd_word = head_ext;
            OFS_STATUS:         rd_word = st;
            default:            rd_word = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf       <= 1'b0;
         udf       <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_tid   <= '0;
         rsp_data  <= '0;
         rsp_hit   <= 1'b0;
      end else begin
         // Set events win over a same-cycle clear.
         ovf       <= ovf_set || (ovf && !clr);
         udf       <= udf_set || (udf && !clr);
         rsp_valid <= rd_valid;
         rsp_hit   <= rd_valid && rd_in;
         if (rd_valid) begin
            rsp_tid  <= rd_tid;
            rsp_data <= rd_word;
         end
      end
   end

endmodule

// File: tb/tb_mmio_fifo_regs.sv
// Bench for mmio_fifo_regs: directed vector table, reset corner, and random traffic vs a queue model.
module tb_mmio_fifo_regs;

   localparam logic [15:0] B   = 16'h0020;
   localparam logic [15:0] DAT = B + 16'd0;
   localparam logic [15:0] STS = B + 16'd2;
   localparam logic [15:0] PEK = B + 16'd4;
   localparam logic [15:0] CTL = B + 16'd6;
   localparam logic [63:0] E_ST = 64'h1_0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_valid = 1'b0, rd_valid = 1'b0;
   logic [15:0] wr_addr = '0, rd_addr = '0;
   logic [63:0] wr_data = '0;
   logic [8:0]  rd_tid = '0;
   logic        rsp_valid, rsp_hit, almost_full, empty, full;
   logic [8:0]  rsp_tid;
   logic [63:0] rsp_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mmio_fifo_regs dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_tid(rd_tid),
      .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
      .almost_full(almost_full), .empty(empty), .full(full)
   );

   typedef struct {
      logic        wv;
      logic [15:0] wa;
      logic [63:0] wd;
      logic        rv;
      logic [15:0] ra;
      logic        hit;
      logic [63:0] data;
      logic        e, f, af;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic wv, input logic [15:0] wa, input logic [63:0] wd,
                               input logic rv, input logic [15:0] ra, input logic hit,
                               input logic [63:0] data, input logic e, input logic f, input logic af);
      vec_t v;
      v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra;
      v.hit = hit; v.data = data; v.e = e; v.f = f; v.af = af;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input logic wv, input logic [15:0] wa, input logic [63:0] wd,
                        input logic rv, input logic [15:0] ra, input logic [8:0] tid);
      wr_valid = wv; wr_addr = wa; wr_data = wd;
      rd_valid = rv; rd_addr = ra; rd_tid = tid;
      @(posedge clk);
      #1;
      wr_valid = 1'b0; rd_valid = 1'b0;
   endtask

   // Reference model: FIFO contents as a queue plus the two sticky flags.
   logic [63:0] mq[$];
   logic        m_ovf, m_udf;

   function automatic void model_step(input logic wv, input logic [15:0] wa, input logic [63:0] wd,
                                      input logic rv, input logic [15:0] ra,
                                      output logic ehit, output logic [63:0] edata);
      int   n = mq.size();
      int   rofs = int'(ra) - int'(B);
      int   wofs = int'(wa) - int'(B);
      logic whit = (wofs >= 0) && (wofs <= 7);
      logic ovf_s = 1'b0, udf_s = 1'b0;
      ehit  = (rofs >= 0) && (rofs <= 7);
      edata = '0;
      if (rv && ehit) begin
         if ((rofs == 0 || rofs == 4) && n > 0) edata = mq[0];
         if (rofs == 2) edata = {28'd0, m_udf, m_ovf, n == 8, n == 0, 24'd0, 8'(n)};
      end
      if (rv && ehit && rofs == 0) begin
         if (n > 0) void'(mq.pop_front());
         else udf_s = 1'b1;
      end
      if (wv && whit && wofs == 0) begin
         if (mq.size() < 8) mq.push_back(wd);
         else ovf_s = 1'b1;
      end
      if (wv && whit && wofs == 6 && wd[0]) mq.delete();
      m_ovf = ovf_s || (m_ovf && !(wv && whit && wofs == 6 && wd[1]));
      m_udf = udf_s || (m_udf && !(wv && whit && wofs == 6 && wd[1]));
   endfunction

   initial begin
      logic        ehit;
      logic [63:0] edata;
      logic [8:0]  tid;
      logic        wv, rv;
      logic [15:0] wa, ra;
      logic [63:0] wd;

      // Directed vectors from the reset state.
      add(0, 0, 0, 1, STS, 1, E_ST, 1, 0, 0);
      add(1, DAT, 64'hA, 0, 0, 0, 0, 0, 0, 0);
      add(1, DAT, 64'hB, 0, 0, 0, 0, 0, 0, 0);
      add(1, DAT, 64'hC, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 1, PEK, 1, 64'hA, 0, 0, 0);
      add(0, 0, 0, 1, STS, 1, 64'h3, 0, 0, 0);
      add(0, 0, 0, 1, DAT, 1, 64'hA, 0, 0, 0);
      add(0, 0, 0, 1, DAT, 1, 64'hB, 0, 0, 0);
      add(0, 0, 0, 1, DAT, 1, 64'hC, 1, 0, 0);
      add(0, 0, 0, 1, STS, 1, E_ST, 1, 0, 0);
      for (int k = 1; k <= 8; k++) add(1, DAT, 64'(k), 0, 0, 0, 0, 0, k == 8, k >= 6);
      add(1, DAT, 64'd9, 0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 0, 1, STS, 1, 64'h6_0000_0008, 0, 1, 1);
      for (int k = 1; k <= 8; k++) add(0, 0, 0, 1, DAT, 1, 64'(k), k == 8, 0, (8 - k) >= 6);
      add(0, 0, 0, 1, DAT, 1, 64'h0, 1, 0, 0);
      add(0, 0, 0, 1, STS, 1, 64'hD_0000_0000, 1, 0, 0);
      add(1, CTL, 64'h2, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, STS, 1, E_ST, 1, 0, 0);
      for (int k = 0; k < 8; k++) add(1, DAT, 64'h11 + 64'(k), 0, 0, 0, 0, 0, k == 7, k >= 5);
      add(1, DAT, 64'h55, 1, DAT, 1, 64'h11, 0, 1, 1);
      add(0, 0, 0, 1, STS, 1, 64'h2_0000_0008, 0, 1, 1);
      for (int k = 1; k <= 7; k++) add(0, 0, 0, 1, DAT, 1, 64'h11 + 64'(k), 0, 0, (8 - k) >= 6);
      add(0, 0, 0, 1, DAT, 1, 64'h55, 1, 0, 0);
      for (int k = 0; k < 3; k++) add(1, DAT, 64'h21 + 64'(k), 0, 0, 0, 0, 0, 0, 0);
      add(1, CTL, 64'h1, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, STS, 1, E_ST, 1, 0, 0);
      add(0, 0, 0, 1, 16'h0010, 0, 64'h0, 1, 0, 0);
      add(1, DAT, 64'h31, 0, 0, 0, 0, 0, 0, 0);
      add(1, DAT, 64'h32, 0, 0, 0, 0, 0, 0, 0);
      add(1, CTL, 64'h1, 1, DAT, 1, 64'h31, 1, 0, 0);
      add(0, 0, 0, 1, PEK, 1, 64'h0, 1, 0, 0);
      add(0, 0, 0, 1, CTL, 1, 64'h0, 1, 0, 0);
      add(1, STS, 64'hFF, 0, 0, 0, 0, 1, 0, 0);
      add(1, B + 16'd1, 64'h77, 0, 0, 0, 0, 1, 0, 0);
      add(1, 16'h0028, 64'h99, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, STS, 1, E_ST, 1, 0, 0);
      add(0, 0, 0, 1, B + 16'd7, 1, 64'h0, 1, 0, 0);
      add(0, 0, 0, 1, 16'h0028, 0, 64'h0, 1, 0, 0);
      add(0, 0, 0, 1, 16'h001F, 0, 64'h0, 1, 0, 0);
      add(1, DAT, 64'h5, 0, 0, 0, 0, 0, 0, 0);
      add(1, CTL, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 1, STS, 1, 64'h1, 0, 0, 0);
      add(1, CTL, 64'h1, 0, 0, 0, 0, 1, 0, 0);
      add(1, CTL, 64'h2, 1, DAT, 1, 64'h0, 1, 0, 0);
      add(0, 0, 0, 1, STS, 1, 64'h9_0000_0000, 1, 0, 0);
      add(1, CTL, 64'h2, 1, STS, 1, 64'h9_0000_0000, 1, 0, 0);
      add(0, 0, 0, 1, STS, 1, E_ST, 1, 0, 0);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset rsp_valid", 64'(rsp_valid), 0);
      chk("reset rsp_tid", 64'(rsp_tid), 0);
      chk("reset rsp_data", rsp_data, 0);
      chk("reset rsp_hit", 64'(rsp_hit), 0);
      chk("reset empty", 64'(empty), 1);
      chk("reset full", 64'(full), 0);
      chk("reset almost_full", 64'(almost_full), 0);

      foreach (tbl[i]) begin
         tid = 9'((i * 7 + 5) % 512);
         apply(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra, tid);
         chk($sformatf("vec%0d rsp_valid", i), 64'(rsp_valid), 64'(tbl[i].rv));
         if (tbl[i].rv) begin
            chk($sformatf("vec%0d rsp_tid", i), 64'(rsp_tid), 64'(tid));
            chk($sformatf("vec%0d rsp_hit", i), 64'(rsp_hit), 64'(tbl[i].hit));
            chk($sformatf("vec%0d rsp_data", i), rsp_data, tbl[i].data);
         end
         chk($sformatf("vec%0d empty", i), 64'(empty), 64'(tbl[i].e));
         chk($sformatf("vec%0d full", i), 64'(full), 64'(tbl[i].f));
         chk($sformatf("vec%0d almost_full", i), 64'(almost_full), 64'(tbl[i].af));
      end

      // Reset mid-operation with a read in flight.
      for (int k = 0; k < 4; k++) apply(1, DAT, 64'h40 + 64'(k), 0, 0, 0);
      chk("pre-reset empty", 64'(empty), 0);
      rst = 1'b1;
      apply(0, 0, 0, 1, STS, 9'd77);
      rst = 1'b0;
      chk("mid-reset rsp_valid", 64'(rsp_valid), 0);
      chk("mid-reset empty", 64'(empty), 1);
      apply(0, 0, 0, 1, STS, 9'd78);
      chk("post-reset status", rsp_data, E_ST);
      chk("post-reset tid", 64'(rsp_tid), 78);

      // Random traffic against the queue model, starting from empty.
      mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         logic heavy_push = ((i / 200) % 2) == 0;
         wv = ($urandom_range(0, 99) < (heavy_push ? 70 : 35));
         rv = ($urandom_range(0, 99) < (heavy_push ? 35 : 70));
         case ($urandom_range(0, 9))
            0:       wa = CTL;
            1:       wa = B + 16'($urandom_range(1, 7));
            2:       wa = 16'($urandom);
            default: wa = DAT;
         endcase
         case ($urandom_range(0, 9))
            0, 1:    ra = STS;
            2:       ra = PEK;
            3:       ra = 16'($urandom);
            4:       ra = B + 16'($urandom_range(1, 7));
            default: ra = DAT;
         endcase
         wd = {$urandom(), $urandom()};
         if (wa == CTL && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
         tid = 9'($urandom);
         model_step(wv, wa, wd, rv, ra, ehit, edata);
         apply(wv, wa, wd, rv, ra, tid);
         chk("rnd rsp_valid", 64'(rsp_valid), 64'(rv));
         if (rv) begin
            chk("rnd rsp_tid", 64'(rsp_tid), 64'(tid));
            chk("rnd rsp_hit", 64'(rsp_hit), 64'(ehit));
            chk("rnd rsp_data", rsp_data, edata);
         end
         chk("rnd empty", 64'(empty), 64'(mq.size() == 0));
         chk("rnd full", 64'(full), 64'(mq.size() == 8));
         chk("rnd almost_full", 64'(almost_full), 64'(mq.size() >= 6));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
